// File: rtl/pmem_phase_sched.sv
`default_nettype none
// ============================================================================
// Module      : pmem_phase_sched
// Description : Phase scheduler for the parallel memory write-read engine.
//               Loads sixteen 16-bit words over a valid/ready stream, then
//               walks four timed read phases. Each phase drives a one-hot
//               phase enable and captures one nibble of the result from bit
//               BIT_SEL of four consecutive entries. The assembled word is
//               offered through a valid/ready output handshake.
//               Optional build macro PMEM_PARITY_EN adds output result_par,
//               the XOR of all result bits.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_phase_sched #(
    parameter int PHASE_CYCLES = 2,   // clock cycles per read phase, 1..16
    parameter int BIT_SEL      = 0    // sampled bit of each entry, 0..15
) (
    input  logic        clk,
    input  logic        rst,           // synchronous, active-low
    input  logic        start,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  ph_en,
    output logic        busy,
    output logic [15:0] result,
    output logic        result_valid,
    input  logic        result_ready
`ifdef PMEM_PARITY_EN
    ,
    output logic        result_par
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Cycle counter must hold PHASE_CYCLES-1 (at most 15).
    localparam int CYC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    localparam logic [CYC_W-1:0] c_CYC_LAST = CYC_W'(PHASE_CYCLES - 1);
    localparam logic [CYC_W-1:0] c_CYC_ONE  = CYC_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_LOAD  = 2'd1;
    localparam logic [1:0] c_S_PHASE = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [15:0] c_RESULT_INIT = 16'hFFFF;
    localparam logic [3:0]  c_ADDR_LAST   = 4'd15;
    localparam logic [1:0]  c_PHASE_LAST  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [3:0]       r_wr_addr;
    logic [1:0]       r_phase;
    logic [CYC_W-1:0] r_cyc;
    logic [15:0]      r_mem [16];
    logic [15:0]      r_result;

    // ------------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------------
    logic       w_start_acc;   // start accepted in IDLE
    logic       w_beat;        // a word is written this cycle
    logic       w_last_beat;   // the word going into entry 15
    logic       w_phase_end;   // final cycle of the current read phase
    logic       w_res_acc;     // consumer takes the result
    logic [3:0] w_nibble;      // bits gathered by the current phase
    logic       w_unused_mem;  // sink for entry bits that are never sampled

    assign w_start_acc = (r_state == c_S_IDLE) && start;
    assign w_beat      = (r_state == c_S_LOAD) && in_valid;
    assign w_last_beat = w_beat && (r_wr_addr == c_ADDR_LAST);
    assign w_phase_end = (r_state == c_S_PHASE) && (r_cyc == c_CYC_LAST);
    assign w_res_acc   = (r_state == c_S_DONE) && result_ready;

    // Gather BIT_SEL of the four entries belonging to the active phase;
    // entry 4k+j lands in nibble bit j.
    always_comb begin
        w_nibble = 4'h0;
        for (int j = 0; j < 4; j++) begin
            w_nibble[j] = r_mem[{r_phase, 2'(j)}][BIT_SEL];
        end
    end

    // Only BIT_SEL of each stored word feeds the result; fold the rest away.
    always_comb begin
        w_unused_mem = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_unused_mem = w_unused_mem ^ (^r_mem[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer: state, write address, phase index and phase cycle counter
    // ------------------------------------------------------------------------
    // Advance the load/phase/done sequence; reset aborts from any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_S_IDLE;
            r_wr_addr <= 4'd0;
            r_phase   <= 2'd0;
            r_cyc     <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state   <= c_S_LOAD;
                        r_wr_addr <= 4'd0;
                    end
                end
                c_S_LOAD: begin
                    if (w_beat) begin
                        // Address stops at 15: leaving LOAD on that beat
                        // means it never needs to wrap.
                        if (w_last_beat) begin
                            r_state <= c_S_PHASE;
                            r_phase <= 2'd0;
                            r_cyc   <= '0;
                        end else begin
                            r_wr_addr <= r_wr_addr + 4'd1;
                        end
                    end
                end
                c_S_PHASE: begin
                    if (r_cyc == c_CYC_LAST) begin
                        r_cyc <= '0;
                        if (r_phase == c_PHASE_LAST) begin
                            r_state <= c_S_DONE;
                        end else begin
                            r_phase <= r_phase + 2'd1;
                        end
                    end else begin
                        r_cyc <= r_cyc + c_CYC_ONE;
                    end
                end
                c_S_DONE: begin
                    if (result_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Word bank
    // ------------------------------------------------------------------------
    // Store each accepted word; reset clears the whole bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_beat) begin
            r_mem[r_wr_addr] <= in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Result assembly
    // ------------------------------------------------------------------------
    // Preset to all-ones on start, then fill one nibble at each phase end.
    // Nibbles not yet reached keep reading 4'hF.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_result <= c_RESULT_INIT;
        end else if (w_start_acc) begin
            r_result <= c_RESULT_INIT;
        end else if (w_phase_end) begin
            r_result[{r_phase, 2'b00} +: 4] <= w_nibble;
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs, decoded only from registered state
    // ------------------------------------------------------------------------
    assign in_ready     = (r_state == c_S_LOAD);
    assign busy         = (r_state != c_S_IDLE);
    assign result_valid = (r_state == c_S_DONE);
    assign result       = r_result;

    // One-hot phase enable, quiet outside the read phases.
    always_comb begin
        ph_en = 4'b0000;
        if (r_state == c_S_PHASE) begin
            ph_en = 4'b0001 << r_phase;
        end
    end

`ifdef PMEM_PARITY_EN
    // Parity follows the registered result; all-ones reset gives 0.
    assign result_par = ^r_result;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_phase_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pmem_phase_sched
// Description : Self-checking bench for pmem_phase_sched. Instance 0 uses the
//               default parameters, instance 1 uses PHASE_CYCLES=1 and
//               BIT_SEL=15. A reference model derives every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_phase_sched;

    typedef logic [15:0] word_arr_t [16];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s      [2];
    logic        start_s    [2];
    logic [15:0] in_data_s  [2];
    logic        in_valid_s [2];
    logic        in_ready_s [2];
    logic [3:0]  ph_en_s    [2];
    logic        busy_s     [2];
    logic [15:0] result_s   [2];
    logic        rv_s       [2];
    logic        rr_s       [2];
`ifdef PMEM_PARITY_EN
    logic        par_s      [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pmem_phase_sched u_dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]),
        .in_data(in_data_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .ph_en(ph_en_s[0]), .busy(busy_s[0]), .result(result_s[0]),
        .result_valid(rv_s[0]), .result_ready(rr_s[0])
`ifdef PMEM_PARITY_EN
        , .result_par(par_s[0])
`endif
    );

    pmem_phase_sched #(.PHASE_CYCLES(1), .BIT_SEL(15)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]),
        .in_data(in_data_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .ph_en(ph_en_s[1]), .busy(busy_s[1]), .result(result_s[1]),
        .result_valid(rv_s[1]), .result_ready(rr_s[1])
`ifdef PMEM_PARITY_EN
        , .result_par(par_s[1])
`endif
    );

    function automatic int pc_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic int bs_of(input int u);
        return (u == 0) ? 0 : 15;
    endfunction

    // Reference: result bit i is bit BIT_SEL of entry i.
    function automatic logic [15:0] model_result(input word_arr_t d, input int bs);
        logic [15:0] r;
        logic [15:0] w;
        r = 16'h0;
        for (int i = 0; i < 16; i++) begin
            w    = d[i];
            r[i] = w[bs];
        end
        return r;
    endfunction

    // Result after the first n phases completed: later nibbles still 4'hF.
    function automatic logic [15:0] model_partial(input logic [15:0] full, input int n);
        logic [15:0] r;
        r = full;
        for (int k = n; k < 4; k++) r[4*k +: 4] = 4'hF;
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input int u, input logic [15:0] exp_res, input string tag);
        check_val({tag, "_busy"},     busy_s[u],     0);
        check_val({tag, "_ph_en"},    ph_en_s[u],    0);
        check_val({tag, "_in_ready"}, in_ready_s[u], 0);
        check_val({tag, "_rvalid"},   rv_s[u],       0);
        check_val({tag, "_result"},   result_s[u],   exp_res);
`ifdef PMEM_PARITY_EN
        check_val({tag, "_par"},      par_s[u],      ^exp_res);
`endif
    endtask

    // gap_mode: 0 continuous, 1 valid low every other cycle, 2 random gaps.
    // rdy_delay: <0 holds result_ready high throughout, else DONE cycles
    // with result_ready low (and a stray start pulse) before acceptance.
    task automatic run_seq(input int u, input word_arr_t d, input int gap_mode,
                           input int rdy_delay, input bit abort_ph2);
        logic [15:0] exp;
        int pc;
        int i;
        int cnt;
        bit v;
        exp = model_result(d, bs_of(u));
        pc  = pc_of(u);

        check_val("pre_busy", busy_s[u], 0);
        start_s[u] = 1'b1;
        rr_s[u]    = (rdy_delay < 0);
        @(negedge clk);
        start_s[u] = 1'b0;
        check_val("load_busy",   busy_s[u],   1);
        check_val("load_result", result_s[u], 16'hFFFF);

        i = 0;
        cnt = 0;
        while (i < 16 && cnt < 400) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cnt % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid_s[u] = v;
            in_data_s[u]  = v ? d[i] : 16'($urandom);
            check_val("load_in_ready", in_ready_s[u], 1);
            check_val("load_ph_en",    ph_en_s[u],    0);
            @(negedge clk);
            if (v) i++;
            cnt++;
        end
        in_valid_s[u] = 1'b0;
        if (i < 16) check_val("load_timeout", 0, 1);

        for (int t = 0; t < 4 * pc; t++) begin
            int ph;
            ph = t / pc;
            if (abort_ph2 && ph == 2) begin
                rst_s[u] = 1'b0;
                @(negedge clk);
                rst_s[u] = 1'b1;
                check_idle(u, 16'hFFFF, "abort");
                return;
            end
            check_val("ph_en",         ph_en_s[u],    4'b0001 << ph);
            check_val("ph_partial",    result_s[u],   model_partial(exp, ph));
            check_val("ph_rvalid",     rv_s[u],       0);
            check_val("ph_in_ready",   in_ready_s[u], 0);
            @(negedge clk);
        end

        check_val("done_rvalid", rv_s[u],     1);
        check_val("done_ph_en",  ph_en_s[u],  0);
        check_val("done_busy",   busy_s[u],   1);
        check_val("done_result", result_s[u], exp);
`ifdef PMEM_PARITY_EN
        check_val("done_par",    par_s[u],    ^exp);
`endif
        if (rdy_delay >= 0) begin
            for (int j = 0; j < rdy_delay; j++) begin
                start_s[u] = 1'b1;
                @(negedge clk);
                check_val("hold_rvalid", rv_s[u],     1);
                check_val("hold_result", result_s[u], exp);
            end
            start_s[u] = 1'b0;
            rr_s[u]    = 1'b1;
        end
        @(negedge clk);
        rr_s[u] = 1'b0;
        check_idle(u, exp, "post");
    endtask

    // Global guard so a stuck design still terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_arr_t d;
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b0; start_s[u] = 1'b0; in_data_s[u] = 16'h0;
            in_valid_s[u] = 1'b0; rr_s[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) check_idle(u, 16'hFFFF, "reset");
        for (int u = 0; u < 2; u++) rst_s[u] = 1'b1;
        @(negedge clk);

        // Basic, backpressure, result_ready held high (default instance).
        for (int i = 0; i < 16; i++) d[i] = 16'(i);
        run_seq(0, d, 0, 0, 1'b0);
        run_seq(0, d, 1, 5, 1'b0);
        run_seq(0, d, 0, -1, 1'b0);

        // Top bit set only in entries 4..7 with BIT_SEL=15.
        for (int i = 0; i < 16; i++) d[i] = (i >= 4 && i <= 7) ? 16'h8000 : 16'h0000;
        run_seq(1, d, 0, 0, 1'b0);

        // Abort during phase 2, then a fresh all-ones load.
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 16; i++) d[i] = 16'($urandom);
            run_seq(u, d, 2, 0, 1'b1);
            for (int i = 0; i < 16; i++) d[i] = 16'hFFFF;
            run_seq(u, d, 0, 1, 1'b0);
        end

        // Randomized runs on both instances.
        for (int n = 0; n < 16; n++) begin
            for (int u = 0; u < 2; u++) begin
                int dly;
                for (int i = 0; i < 16; i++) d[i] = 16'($urandom);
                dly = int'($urandom_range(0, 5)) - 1;
                run_seq(u, d, int'($urandom_range(0, 2)), dly, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
